// File: rtl/tm_program_loader.sv
// Buffers program nibbles and replays them to a TuringMachine as timed Next/Done pulses.
// Optional TM_LOADER_ABORT_EN adds an abort input that returns any sequence to IDLE.
module tm_program_loader #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 3,
  parameter int PULSE_CYC  = 2,
  parameter int GAP_CYC    = 2,
  parameter int CNT_W      = 8
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              run_start,
  input  logic [CNT_W-1:0]  run_steps,
`ifdef TM_LOADER_ABORT_EN
  input  logic              abort,
`endif
  output logic [DATA_W-1:0] input_data,
  output logic              Next,
  output logic              Done,
  output logic              busy,
  output logic              loaded,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  step_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [AW:0] PINC = (AW+1)'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_DSET,
    S_DPULSE,
    S_DGAP,
    S_LOADED,
    S_RSET,
    S_RPULSE,
    S_RGAP
  } state_t;

  state_t r_state;

  logic [AW:0]       r_wr;
  logic [AW:0]       r_rd;
  logic [DATA_W:0]   r_mem [FIFO_DEPTH];
  logic [7:0]        r_tmr;
  logic              r_last;
  logic [DATA_W-1:0] r_data;
  logic              r_next;
  logic              r_done;
  logic [CNT_W-1:0]  r_lcnt;
  logic [CNT_W-1:0]  r_scnt;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_run_go;
  logic              w_tend;
  logic              w_abort;
  logic [DATA_W:0]   w_head;
  logic [7:0]        w_tlen;

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = in_valid && !w_full;
  assign w_head  = r_mem[r_rd[AW-1:0]];

`ifdef TM_LOADER_ABORT_EN
  assign w_abort = abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_run_go = (r_state == S_LOADED) && run_start &&
                    (run_steps != '0);

  always_comb begin
    w_tlen = '0;
    unique case (r_state)
      S_SETUP, S_DSET, S_RSET:     w_tlen = 8'(SETUP_CYC - 1);
      S_PULSE, S_DPULSE, S_RPULSE: w_tlen = 8'(PULSE_CYC - 1);
      S_GAP, S_DGAP, S_RGAP:       w_tlen = 8'(GAP_CYC - 1);
      default:                     w_tlen = '0;
    endcase
  end

  assign w_tend = (r_tmr == w_tlen);

  // A new nibble is only taken while nothing is being driven to the machine.
  assign w_pop = !w_abort && !w_empty && (
                   (r_state == S_IDLE) ||
                   ((r_state == S_LOADED) && !w_run_go) ||
                   ((r_state == S_GAP) && w_tend && !r_last));

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= {in_last, in_data};
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_wr    <= '0;
      r_rd    <= '0;
      r_tmr   <= '0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_next  <= 1'b0;
      r_done  <= 1'b0;
      r_lcnt  <= '0;
      r_scnt  <= '0;
    end else begin
      r_tmr <= r_tmr + 8'd1;
      if (w_push) r_wr <= r_wr + PINC;

      unique case (r_state)
        S_IDLE: begin
          if (w_pop) r_lcnt <= r_lcnt + ONE;
        end
        S_LOADED: begin
          if (w_run_go) begin
            r_scnt  <= run_steps;
            r_tmr   <= '0;
            r_state <= S_RSET;
          end else if (w_pop) begin
            r_lcnt <= ONE;
          end
        end
        S_SETUP: begin
          if (w_tend) begin
            r_next  <= 1'b1;
            r_tmr   <= '0;
            r_state <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (w_tend) begin
            r_next  <= 1'b0;
            r_tmr   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_tend) begin
            r_tmr <= '0;
            if (r_last) r_state <= S_DSET;
            else if (w_pop) r_lcnt <= r_lcnt + ONE;
            else r_state <= S_IDLE;
          end
        end
        S_DSET: begin
          if (w_tend) begin
            r_done  <= 1'b1;
            r_tmr   <= '0;
            r_state <= S_DPULSE;
          end
        end
        S_DPULSE: begin
          if (w_tend) begin
            r_done  <= 1'b0;
            r_tmr   <= '0;
            r_state <= S_DGAP;
          end
        end
        S_DGAP: begin
          if (w_tend) begin
            r_tmr   <= '0;
            r_state <= S_LOADED;
          end
        end
        S_RSET: begin
          if (w_tend) begin
            r_next  <= 1'b1;
            r_tmr   <= '0;
            r_state <= S_RPULSE;
          end
        end
        S_RPULSE: begin
          if (w_tend) begin
            r_next  <= 1'b0;
            r_scnt  <= r_scnt - ONE;
            r_tmr   <= '0;
            r_state <= S_RGAP;
          end
        end
        S_RGAP: begin
          if (w_tend) begin
            r_tmr   <= '0;
            r_state <= (r_scnt == '0) ? S_LOADED : S_RSET;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_pop) begin
        r_rd    <= r_rd + PINC;
        r_data  <= w_head[DATA_W-1:0];
        r_last  <= w_head[DATA_W];
        r_tmr   <= '0;
        r_state <= S_SETUP;
      end

      // Abort drops everything queued but keeps the program length seen so far.
      if (w_abort) begin
        r_state <= S_IDLE;
        r_next  <= 1'b0;
        r_done  <= 1'b0;
        r_scnt  <= '0;
        r_rd    <= r_wr;
      end
    end
  end

  assign in_ready   = !w_full;
  assign input_data = r_data;
  assign Next       = r_next;
  assign Done       = r_done;
  assign load_count = r_lcnt;
  assign step_count = r_scnt;
  assign loaded     = (r_state == S_LOADED);
  assign busy       = (r_state != S_IDLE) && (r_state != S_LOADED);

endmodule

// File: tb/tb_tm_program_loader.sv
// Directed bench for tm_program_loader: load, run, ignore cases, reset, reload.
// Pulse widths, periods and setup times are measured on every falling edge.
module tb_tm_program_loader;

  logic       clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       run_start = 1'b0;
  logic [7:0] run_steps = '0;
`ifdef TM_LOADER_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic [3:0] input_data;
  logic       Next;
  logic       Done;
  logic       busy;
  logic       loaded;
  logic [7:0] load_count;
  logic [7:0] step_count;

  tm_program_loader dut (
    .clock      (clock),
    .Reset      (Reset),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .run_start  (run_start),
    .run_steps  (run_steps),
`ifdef TM_LOADER_ABORT_EN
    .abort      (abort),
`endif
    .input_data (input_data),
    .Next       (Next),
    .Done       (Done),
    .busy       (busy),
    .loaded     (loaded),
    .load_count (load_count),
    .step_count (step_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int stab = 0;
  logic [3:0] prev_id = '0;
  logic prev_nx = 1'b0;
  logic prev_dn = 1'b0;
  int n_rises, d_rises, both, last_rise;
  int min_per, max_per, min_hi, max_hi, hi;
  int d_min_hi, d_max_hi, dhi, min_stab;
  int first_step, last_step;
  logic [3:0] rdat [16];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_rises = 0; d_rises = 0; both = 0; last_rise = 0;
    min_per = 999; max_per = 0; min_hi = 999; max_hi = 0; hi = 0;
    d_min_hi = 999; d_max_hi = 0; dhi = 0; min_stab = 999;
    first_step = -1; last_step = -1;
    for (int i = 0; i < 16; i++) rdat[i] = '0;
  endtask

  task automatic tick();
    int per;
    @(negedge clock);
    cyc++;
    if (input_data !== prev_id) stab = 1;
    else stab++;
    prev_id = input_data;
    if (Next === 1'b1 && prev_nx === 1'b0) begin
      if (n_rises < 16) rdat[n_rises] = input_data;
      if (n_rises == 0) first_step = int'(step_count);
      last_step = int'(step_count);
      if (n_rises > 0) begin
        per = cyc - last_rise;
        if (per < min_per) min_per = per;
        if (per > max_per) max_per = per;
      end
      last_rise = cyc;
      if (stab < min_stab) min_stab = stab;
      n_rises++;
      hi = 0;
    end
    if (Next === 1'b1) hi++;
    if (Next === 1'b0 && prev_nx === 1'b1) begin
      if (hi < min_hi) min_hi = hi;
      if (hi > max_hi) max_hi = hi;
    end
    if (Done === 1'b1 && prev_dn === 1'b0) begin
      d_rises++;
      dhi = 0;
    end
    if (Done === 1'b1) dhi++;
    if (Done === 1'b0 && prev_dn === 1'b1) begin
      if (dhi < d_min_hi) d_min_hi = dhi;
      if (dhi > d_max_hi) d_max_hi = dhi;
    end
    if (Next === 1'b1 && Done === 1'b1) both++;
    prev_nx = Next;
    prev_dn = Done;
  endtask

  task automatic push(logic [3:0] d, logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_loaded(int bound);
    int n = 0;
    while (loaded !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk("wait_loaded", loaded, 1);
  endtask

  task automatic wait_next(int bound);
    int n = 0;
    while (Next !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk("wait_next", Next, 1);
  endtask

  initial begin
    clr_stats();
    // Reset for one edge
    tick();
    Reset = 1'b0;
    chk("rst_next", Next, 0);
    chk("rst_done", Done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_data", input_data, 0);
    chk("rst_lcnt", load_count, 0);
    chk("rst_scnt", step_count, 0);

    // Program 3,1,1,2(last)
    clr_stats();
    push(4'd3, 1'b0);
    push(4'd1, 1'b0);
    push(4'd1, 1'b0);
    push(4'd2, 1'b1);
    wait_loaded(100);
    chk("p1_lcnt", load_count, 4);
    chk("p1_rises", n_rises, 4);
    chk("p1_d0", rdat[0], 3);
    chk("p1_d1", rdat[1], 1);
    chk("p1_d2", rdat[2], 1);
    chk("p1_d3", rdat[3], 2);
    chk("p1_minper", min_per, 7);
    chk("p1_maxper", max_per, 7);
    chk("p1_minhi", min_hi, 2);
    chk("p1_maxhi", max_hi, 2);
    chk("p1_setup", min_stab, 4);
    chk("p1_done_n", d_rises, 1);
    chk("p1_done_w", d_max_hi, 2);
    chk("p1_done_wmin", d_min_hi, 2);
    chk("p1_both", both, 0);
    chk("p1_busy", busy, 0);
    chk("p1_data", input_data, 2);

    // Run 10 steps; queue a new program and a stray run_start while busy
    clr_stats();
    run_start = 1'b1;
    run_steps = 8'd10;
    tick();
    run_start = 1'b0;
    chk("r_busy", busy, 1);
    chk("r_loaded", loaded, 0);
    chk("r_scnt0", step_count, 10);
    push(4'd4, 1'b0);
    push(4'd5, 1'b0);
    push(4'd6, 1'b0);
    push(4'd7, 1'b1);
    chk("r_full", in_ready, 0);
    run_start = 1'b1;
    run_steps = 8'd3;
    tick();
    run_start = 1'b0;
    wait_loaded(200);
    chk("r_rises", n_rises, 10);
    chk("r_minper", min_per, 7);
    chk("r_maxper", max_per, 7);
    chk("r_hi", max_hi, 2);
    chk("r_done", d_rises, 0);
    chk("r_first", first_step, 10);
    chk("r_last", last_step, 1);
    chk("r_scnt", step_count, 0);
    chk("r_data", input_data, 2);

    // Queued program loads from LOADED: count restarts at 1
    clr_stats();
    tick();
    chk("q_loaded", loaded, 0);
    chk("q_lcnt1", load_count, 1);
    chk("q_data0", input_data, 4);
    chk("q_busy", busy, 1);
    wait_loaded(100);
    chk("q_lcnt", load_count, 4);
    chk("q_rises", n_rises, 4);
    chk("q_d3", rdat[3], 7);
    chk("q_setup", min_stab, 4);
    chk("q_done", d_rises, 1);

    // run_steps = 0 is ignored
    clr_stats();
    run_start = 1'b1;
    run_steps = 8'd0;
    tick();
    run_start = 1'b0;
    tick(); tick(); tick();
    chk("z_loaded", loaded, 1);
    chk("z_busy", busy, 0);
    chk("z_rises", n_rises, 0);
    chk("z_scnt", step_count, 0);

    // Reset during a run pulse, with a nibble pending in the FIFO
    run_start = 1'b1;
    run_steps = 8'd5;
    tick();
    run_start = 1'b0;
    push(4'd9, 1'b0);
    wait_next(20);
    Reset = 1'b1;
    tick();
    chk("x_next", Next, 0);
    chk("x_busy", busy, 0);
    chk("x_loaded", loaded, 0);
    chk("x_scnt", step_count, 0);
    chk("x_lcnt", load_count, 0);
    chk("x_data", input_data, 0);
    chk("x_ready", in_ready, 1);
    Reset = 1'b0;
    tick(); tick(); tick();
    chk("x_flushed", busy, 0);

    // Reload after reset
    clr_stats();
    push(4'd10, 1'b1);
    wait_loaded(60);
    chk("rl_lcnt", load_count, 1);
    chk("rl_data", input_data, 10);
    chk("rl_rises", n_rises, 1);
    chk("rl_done", d_rises, 1);

    // Single-nibble program pushed while LOADED
    clr_stats();
    push(4'd11, 1'b1);
    tick();
    chk("s_loaded", loaded, 0);
    chk("s_lcnt", load_count, 1);
    wait_loaded(60);
    chk("s_lcnt_end", load_count, 1);
    chk("s_data", input_data, 11);
    chk("s_rises", n_rises, 1);
    chk("s_done", d_rises, 1);

`ifdef TM_LOADER_ABORT_EN
    run_start = 1'b1;
    run_steps = 8'd3;
    tick();
    run_start = 1'b0;
    wait_next(20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("a_next", Next, 0);
    chk("a_busy", busy, 0);
    chk("a_loaded", loaded, 0);
    chk("a_scnt", step_count, 0);
    chk("a_lcnt", load_count, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
